// File: rtl/sw_align_controller.sv
// Job sequencer for a Smith-Waterman scoring array: it latches the query, clears the array,
// streams target bases into it, waits for the score and hands it off. Optional feature macro: SWC_DRAIN_TIMEOUT_EN.
module sw_align_controller #(
  parameter int SCORE_WIDTH = 12,
  parameter int LENGTH      = 128,
  parameter int LOG_LENGTH  = $clog2(LENGTH) + 1,
  parameter int DRAIN_MAX   = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2*LENGTH-1:0]    query_in,
  input  logic [LOG_LENGTH-1:0]  query_last,
  input  logic                   tgt_valid,
  input  logic [1:0]             tgt_data,
  input  logic                   tgt_last,
  output logic                   tgt_ready,
  output logic                   arr_rst_n,
  output logic                   arr_en,
  output logic [1:0]             arr_data,
  output logic [2*LENGTH-1:0]    arr_query,
  output logic [LOG_LENGTH-1:0]  arr_counter,
  input  logic                   arr_vld,
  input  logic [SCORE_WIDTH-1:0] arr_result,
  output logic                   res_valid,
  output logic [SCORE_WIDTH-1:0] res_score,
  input  logic                   res_ready,
  output logic                   busy,
  output logic                   err
);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

  state_t                  state_q;
  logic [2*LENGTH-1:0]     arr_query_q;
  logic [LOG_LENGTH-1:0]   arr_counter_q;
  logic [SCORE_WIDTH-1:0]  res_score_q;

`ifdef SWC_DRAIN_TIMEOUT_EN
  localparam int CNT_W = $clog2(DRAIN_MAX) + 1;
  logic [CNT_W-1:0] drain_cnt_q;
  logic             err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      arr_query_q   <= '0;
      arr_counter_q <= '0;
      res_score_q   <= '0;
`ifdef SWC_DRAIN_TIMEOUT_EN
      drain_cnt_q   <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            arr_query_q   <= query_in;
            arr_counter_q <= query_last;
`ifdef SWC_DRAIN_TIMEOUT_EN
            err_q         <= 1'b0;
`endif
            state_q       <= CLEAR;
          end
        end
        CLEAR: state_q <= STREAM;
        STREAM: begin
          if (tgt_valid && tgt_last) begin
`ifdef SWC_DRAIN_TIMEOUT_EN
            drain_cnt_q <= '0;
`endif
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (arr_vld) begin
            res_score_q <= arr_result;
            state_q     <= DONE;
          end
`ifdef SWC_DRAIN_TIMEOUT_EN
          // Count is the number of DRAIN cycles already spent; the last allowed one gives up.
          else if (drain_cnt_q == CNT_W'(DRAIN_MAX - 1)) begin
            res_score_q <= '0;
            err_q       <= 1'b1;
            state_q     <= DONE;
          end else if (drain_cnt_q != '1) begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end
`endif
        end
        DONE: begin
          if (res_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stream forwarding is combinational so a base reaches the array in the cycle it is accepted.
  assign tgt_ready   = (state_q == STREAM);
  assign arr_en      = (state_q == STREAM) && tgt_valid;
  assign arr_data    = (state_q == STREAM) ? tgt_data : 2'b00;
  assign arr_rst_n   = !(rst || (state_q == CLEAR));
  assign arr_query   = arr_query_q;
  assign arr_counter = arr_counter_q;
  assign res_valid   = (state_q == DONE);
  assign res_score   = res_score_q;
  assign busy        = (state_q != IDLE);

`ifdef SWC_DRAIN_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sw_align_controller.sv
// Directed bench for sw_align_controller: job flow, stream gaps, result hold, reset abort, drain timeout.
module tb_sw_align_controller;

  localparam int SW  = 12;
  localparam int LEN = 8;
  localparam int LL  = 4;

  logic          clk = 1'b0;
  logic          rst, start, tgt_valid, tgt_last, arr_vld, res_ready;
  logic [2*LEN-1:0] query_in;
  logic [LL-1:0] query_last;
  logic [1:0]    tgt_data;
  logic [SW-1:0] arr_result;
  logic          tgt_ready, arr_rst_n, arr_en, res_valid, busy, err;
  logic [1:0]    arr_data;
  logic [2*LEN-1:0] arr_query;
  logic [LL-1:0] arr_counter;
  logic [SW-1:0] res_score;

  int n_checks = 0;
  int n_errors = 0;
  int fwd;

  always #5 clk = ~clk;

  sw_align_controller #(
    .SCORE_WIDTH(SW), .LENGTH(LEN), .LOG_LENGTH(LL), .DRAIN_MAX(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .query_in(query_in), .query_last(query_last),
    .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_last(tgt_last), .tgt_ready(tgt_ready),
    .arr_rst_n(arr_rst_n), .arr_en(arr_en), .arr_data(arr_data), .arr_query(arr_query),
    .arr_counter(arr_counter), .arr_vld(arr_vld), .arr_result(arr_result),
    .res_valid(res_valid), .res_score(res_score), .res_ready(res_ready),
    .busy(busy), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [2*LEN-1:0] q, input logic [LL-1:0] last);
    start = 1'b1; query_in = q; query_last = last;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic v, input logic [1:0] d, input logic l);
    tgt_valid = v; tgt_data = d; tgt_last = l;
    #1;
    check("arr_en", {31'd0, arr_en}, {31'd0, v});
    if (v) check("arr_data", {30'd0, arr_data}, {30'd0, d});
    if (arr_en) fwd++;
    tick();
    tgt_valid = 1'b0; tgt_last = 1'b0; tgt_data = 2'b00;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; tgt_valid = 1'b0; tgt_last = 1'b0; tgt_data = 2'b00;
    arr_vld = 1'b0; arr_result = '0; res_ready = 1'b0; query_in = '0; query_last = '0;
    tick(); tick();
    check("rst_arr_rst_n", {31'd0, arr_rst_n}, 32'd0);
    check("rst_tgt_ready", {31'd0, tgt_ready}, 32'd0);
    check("rst_arr_en", {31'd0, arr_en}, 32'd0);
    check("rst_arr_data", {30'd0, arr_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_score", {20'd0, res_score}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_arr_query", {16'd0, arr_query}, 32'd0);
    check("rst_arr_counter", {28'd0, arr_counter}, 32'd0);
    rst = 1'b0;
    #1;
    check("idle_arr_rst_n", {31'd0, arr_rst_n}, 32'd1);

    // Job 1: four back-to-back bases, held result, start ignored in DONE.
    start_job(16'hA5C3, 4'd3);
    check("clr_arr_rst_n", {31'd0, arr_rst_n}, 32'd0);
    check("clr_busy", {31'd0, busy}, 32'd1);
    check("clr_query", {16'd0, arr_query}, 32'hA5C3);
    check("clr_counter", {28'd0, arr_counter}, 32'd3);
    tick();
    check("str_arr_rst_n", {31'd0, arr_rst_n}, 32'd1);
    check("str_tgt_ready", {31'd0, tgt_ready}, 32'd1);
    fwd = 0;
    for (int i = 0; i < 4; i++) beat(1'b1, 2'(i), i == 3);
    check("j1_fwd", fwd, 32'd4);
    check("drn_tgt_ready", {31'd0, tgt_ready}, 32'd0);
    check("drn_arr_en", {31'd0, arr_en}, 32'd0);
    check("drn_res_valid", {31'd0, res_valid}, 32'd0);
    arr_vld = 1'b1; arr_result = 12'h01A;
    tick();
    arr_vld = 1'b0; arr_result = 12'h000;
    check("j1_res_valid", {31'd0, res_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2); query_in = 16'hFFFF; query_last = 4'd7;
      tick();
      check("j1_hold_valid", {31'd0, res_valid}, 32'd1);
      check("j1_hold_score", {20'd0, res_score}, 32'h01A);
      check("j1_hold_query", {16'd0, arr_query}, 32'hA5C3);
      check("j1_hold_counter", {28'd0, arr_counter}, 32'd3);
    end
    start = 1'b0;
    res_ready = 1'b1;
    tick();
    check("j1_idle_busy", {31'd0, busy}, 32'd0);
    check("j1_idle_valid", {31'd0, res_valid}, 32'd0);
    tick();
    check("idle_ready_noeffect", {31'd0, busy}, 32'd0);
    res_ready = 1'b0;
    $display("job1 done: score %0h", res_score);

    // Job 2: gapped stream, stray arr_vld and start during STREAM ignored.
    start_job(16'h1234, 4'd5);
    tick();
    fwd = 0;
    beat(1'b1, 2'd2, 1'b0);
    arr_vld = 1'b1; arr_result = 12'h055; start = 1'b1; query_in = 16'hBEEF;
    beat(1'b0, 2'd0, 1'b0);
    beat(1'b0, 2'd0, 1'b0);
    arr_vld = 1'b0; start = 1'b0;
    beat(1'b1, 2'd1, 1'b0);
    beat(1'b1, 2'd3, 1'b1);
    check("j2_fwd", fwd, 32'd3);
    check("j2_drain_valid", {31'd0, res_valid}, 32'd0);
    check("j2_drain_busy", {31'd0, busy}, 32'd1);
    check("j2_query", {16'd0, arr_query}, 32'h1234);
    tick();
    check("j2_wait_valid", {31'd0, res_valid}, 32'd0);
    arr_vld = 1'b1; arr_result = 12'h7FF;
    tick();
    arr_vld = 1'b0;
    check("j2_res_valid", {31'd0, res_valid}, 32'd1);
    check("j2_res_score", {20'd0, res_score}, 32'h7FF);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("j2_idle", {31'd0, busy}, 32'd0);
    $display("job2 done: forwarded %0d score %0h", fwd, res_score);

    // Job 3: reset mid-stream, then a clean single-base job.
    start_job(16'h5555, 4'd2);
    tick();
    beat(1'b1, 2'd1, 1'b0);
    rst = 1'b1;
    tick();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_tgt_ready", {31'd0, tgt_ready}, 32'd0);
    check("abort_valid", {31'd0, res_valid}, 32'd0);
    check("abort_arr_rst_n", {31'd0, arr_rst_n}, 32'd0);
    check("abort_query", {16'd0, arr_query}, 32'd0);
    rst = 1'b0;
    start_job(16'h00FF, 4'd0);
    check("j3_counter", {28'd0, arr_counter}, 32'd0);
    tick();
    fwd = 0;
    beat(1'b1, 2'd2, 1'b1);
    check("j3_fwd", fwd, 32'd1);
    check("j3_drain_ready", {31'd0, tgt_ready}, 32'd0);
    arr_vld = 1'b1; arr_result = 12'h123;
    tick();
    arr_vld = 1'b0;
    check("j3_res_score", {20'd0, res_score}, 32'h123);
    check("j3_res_valid", {31'd0, res_valid}, 32'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("j3_idle", {31'd0, busy}, 32'd0);
    $display("job3 done: score %0h", res_score);

    // Job 4: the array never answers.
    start_job(16'h0F0F, 4'd1);
    tick();
    beat(1'b1, 2'd3, 1'b1);
`ifdef SWC_DRAIN_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      tick();
      check("tmo_wait_valid", {31'd0, res_valid}, 32'd0);
    end
    tick();
    check("tmo_valid", {31'd0, res_valid}, 32'd1);
    check("tmo_err", {31'd0, err}, 32'd1);
    check("tmo_score", {20'd0, res_score}, 32'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("tmo_err_sticky", {31'd0, err}, 32'd1);
    start_job(16'h0001, 4'd0);
    check("tmo_err_cleared", {31'd0, err}, 32'd0);
    $display("job4 done: timeout flagged");
`else
    for (int i = 0; i < 40; i++) begin
      tick();
      check("drain_wait_busy", {31'd0, busy}, 32'd1);
      check("drain_wait_valid", {31'd0, res_valid}, 32'd0);
      check("drain_wait_err", {31'd0, err}, 32'd0);
    end
    $display("job4 done: still draining after 40 cycles");
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
